// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared types and constants for the A2D conversion scheduler
package a2d_pkg;

  localparam int A2D_RES_W = 12;

  typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_t;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  typedef logic [1:0] rr_idx_t;

  localparam rr_idx_t RR_LFT   = 2'd0;
  localparam rr_idx_t RR_RGHT  = 2'd1;
  localparam rr_idx_t RR_STEER = 2'd2;
  localparam rr_idx_t RR_BATT  = 2'd3;

  function automatic logic [2:0] rr_to_ch(input rr_idx_t rr);
    logic [2:0] ch;
    ch = CH_LFT;
    case (rr)
      RR_LFT:   ch = CH_LFT;
      RR_RGHT:  ch = CH_RGHT;
      RR_STEER: ch = CH_STEER;
      RR_BATT:  ch = CH_BATT;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/a2d_sched.sv
// rtl/a2d_sched.sv - round-robin two-transaction SPI A2D conversion scheduler
module a2d_sched
  import a2d_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 nxt,
  input  logic                 spi_done,
  input  logic [15:0]          spi_resp,
  output logic                 spi_snd,
  output logic [15:0]          spi_cmd,
  output logic [A2D_RES_W-1:0] lft_ld,
  output logic [A2D_RES_W-1:0] rght_ld,
  output logic [A2D_RES_W-1:0] steer_pot,
  output logic [A2D_RES_W-1:0] batt,
  output logic                 busy,
  output logic                 vld,
  output logic [1:0]           vld_ch
);

  state_t  state;
  rr_idx_t rr;

  // Only the 12-bit conversion field of the response carries data.
  logic unused_resp_hi;
  assign unused_resp_hi = ^spi_resp[15:12];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= RR_LFT;
      spi_snd   <= 1'b0;
      spi_cmd   <= 16'h0000;
      busy      <= 1'b0;
      vld       <= 1'b0;
      vld_ch    <= 2'd0;
      lft_ld    <= '0;
      rght_ld   <= '0;
      steer_pot <= '0;
      batt      <= '0;
    end else begin
      spi_snd <= 1'b0;
      vld     <= 1'b0;
      case (state)
        IDLE: begin
          if (nxt) begin
            state   <= CMD;
            spi_snd <= 1'b1;
            busy    <= 1'b1;
            spi_cmd <= {2'b00, rr_to_ch(rr), 11'h000};
          end
        end
        CMD: begin
          if (spi_done) state <= GAP;
        end
        GAP: begin
          // Resend the same command; the result arrives on this second transaction.
          state   <= READ;
          spi_snd <= 1'b1;
        end
        READ: begin
          if (spi_done) begin
            case (rr)
              RR_LFT:   lft_ld    <= spi_resp[A2D_RES_W-1:0];
              RR_RGHT:  rght_ld   <= spi_resp[A2D_RES_W-1:0];
              RR_STEER: steer_pot <= spi_resp[A2D_RES_W-1:0];
              RR_BATT:  batt      <= spi_resp[A2D_RES_W-1:0];
            endcase
            vld    <= 1'b1;
            vld_ch <= rr;
            rr     <= rr + 2'd1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_sched.sv
// tb/tb_a2d_sched.sv - self-checking bench for a2d_sched with SPI slave and reference model
module tb_a2d_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_resp = 16'h0000;
  logic        spi_snd;
  logic [15:0] spi_cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        busy, vld;
  logic [1:0]  vld_ch;

  a2d_sched dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .spi_done(spi_done), .spi_resp(spi_resp),
    .spi_snd(spi_snd), .spi_cmd(spi_cmd), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .steer_pot(steer_pot), .batt(batt), .busy(busy), .vld(vld), .vld_ch(vld_ch)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: conversion stage plus per-channel result array.
  int          m_stage = 0;
  int          m_rr = 0;
  bit          m_snd = 0, m_vld = 0;
  logic [15:0] m_cmd = 0;
  logic [1:0]  m_vch = 0;
  logic [11:0] m_regs [4];
  int          ch_tab [4] = '{0, 4, 5, 6};
  bit          started = 0;

  always @(posedge clk) begin
    started = 1;
    m_snd = 0;
    m_vld = 0;
    if (!rst_n) begin
      m_stage = 0; m_rr = 0; m_cmd = 0; m_vch = 0;
      foreach (m_regs[i]) m_regs[i] = 12'h000;
    end else begin
      case (m_stage)
        0: if (nxt) begin m_stage = 1; m_snd = 1; m_cmd = 16'(ch_tab[m_rr] * 2048); end
        1: if (spi_done) m_stage = 2;
        2: begin m_stage = 3; m_snd = 1; end
        default: if (spi_done) begin
          m_regs[m_rr] = spi_resp[11:0];
          m_vld = 1;
          m_vch = 2'(m_rr);
          m_rr = (m_rr + 1) % 4;
          m_stage = 0;
        end
      endcase
    end
  end

  logic prev_snd = 1'b0;
  always @(negedge clk) begin
    if (started) begin
      chk("spi_snd", spi_snd, m_snd);
      chk("spi_cmd", spi_cmd, m_cmd);
      chk("busy", busy, m_stage != 0);
      chk("vld", vld, m_vld);
      chk("vld_ch", vld_ch, m_vch);
      chk("lft_ld", lft_ld, m_regs[0]);
      chk("rght_ld", rght_ld, m_regs[1]);
      chk("steer_pot", steer_pot, m_regs[2]);
      chk("batt", batt, m_regs[3]);
      chk("snd_back_to_back", spi_snd & prev_snd, 0);
      prev_snd = spi_snd;
    end
  end

  // SPI slave: random latency, junk on odd transactions, queued data on even ones.
  logic [11:0] resp_q [$];
  logic [15:0] cmd_log [$];
  int          vch_log [$];
  bit          stray_req = 0, stray_gap = 0, gap_next = 0, pend = 0;
  int          wait_c = 0, txn = 0, snd_cnt = 0, vld_cnt = 0;

  always @(negedge clk) begin
    spi_done = 1'b0;
    if (!rst_n) begin
      pend = 0; txn = 0; gap_next = 0;
    end else begin
      if (pend) begin
        if (wait_c == 0) begin
          spi_done = 1'b1;
          pend = 0;
          if (txn % 2 == 1) begin
            spi_resp = 16'($urandom);
            gap_next = stray_gap;
          end else if (resp_q.size() > 0) begin
            spi_resp = {4'($urandom), resp_q.pop_front()};
          end else begin
            spi_resp = 16'($urandom);
          end
        end else begin
          wait_c--;
        end
      end else if (gap_next) begin
        spi_done = 1'b1; spi_resp = 16'($urandom); gap_next = 0;
      end else if (stray_req) begin
        spi_done = 1'b1; spi_resp = 16'($urandom); stray_req = 0;
      end
      if (spi_snd) begin
        pend = 1; wait_c = $urandom_range(0, 5); txn++; snd_cnt++;
        cmd_log.push_back(spi_cmd);
      end
      if (vld) begin
        vld_cnt++;
        vch_log.push_back(int'(vld_ch));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic convert(input logic [11:0] v);
    int t;
    int v0;
    v0 = vld_cnt;
    resp_q.push_back(v);
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
    t = 0;
    while (vld_cnt == v0 && t < 200) begin @(negedge clk); t++; end
    chk("convert_timeout", t < 200, 1);
    cyc(1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 500) begin @(negedge clk); t++; end
    chk("idle_timeout", t < 500, 1);
    cyc(2);
  endtask

  initial begin
    int t, s0, v0, sz;
    rst_n = 1'b0;
    cyc(5);
    chk("rst_snd", spi_snd, 0);
    chk("rst_cmd", spi_cmd, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_vld", vld, 0);
    chk("rst_lft", lft_ld, 0);
    chk("rst_batt", batt, 0);
    rst_n = 1'b1;
    cyc(1);

    convert(12'h200);
    convert(12'h1C0);
    convert(12'h7FF);
    convert(12'hABC);
    chk("cmd_log_size", cmd_log.size(), 8);
    if (cmd_log.size() == 8) begin
      chk("cmd0", cmd_log[0], 16'h0000);
      chk("cmd0_resend", cmd_log[1], 16'h0000);
      chk("cmd1", cmd_log[2], 16'h2000);
      chk("cmd2", cmd_log[4], 16'h2800);
      chk("cmd3", cmd_log[6], 16'h3000);
    end
    chk("vch_log_size", vch_log.size(), 4);
    if (vch_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("vld_ch_seq", vch_log[i], i);
    chk("lit_lft", lft_ld, 12'h200);
    chk("lit_rght", rght_ld, 12'h1C0);
    chk("lit_steer", steer_pot, 12'h7FF);
    chk("lit_batt", batt, 12'hABC);

    convert(12'h123);
    chk("wrap_lft", lft_ld, 12'h123);
    chk("wrap_rght", rght_ld, 12'h1C0);
    chk("wrap_steer", steer_pot, 12'h7FF);
    chk("wrap_batt", batt, 12'hABC);

    v0 = vld_cnt;
    stray_req = 1;
    cyc(4);
    chk("stray_idle_vld", vld_cnt, v0);
    chk("stray_idle_busy", busy, 0);

    // nxt held high with stray done in every GAP
    stray_gap = 1;
    s0 = snd_cnt; v0 = vld_cnt;
    nxt = 1'b1;
    t = 0;
    while (vld_cnt - v0 < 4 && t < 1000) begin @(negedge clk); t++; end
    chk("held_nxt_timeout", t < 1000, 1);
    nxt = 1'b0;
    wait_idle();
    stray_gap = 0;
    chk("snd_per_conv", snd_cnt - s0, 2 * (vld_cnt - v0));

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      stray_gap = ($urandom_range(0, 3) == 0);
      nxt = ($urandom_range(0, 3) == 0);
      if (!busy && !nxt && $urandom_range(0, 7) == 0) stray_req = 1;
    end
    nxt = 1'b0;
    stray_gap = 0;
    wait_idle();

    // reset in the middle of a conversion
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    resp_q.delete();
    v0 = vld_cnt;
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
    t = 0;
    while (!(spi_done && busy) && t < 100) begin @(posedge clk); t++; end
    chk("first_done_timeout", t < 100, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("abort_vld", vld_cnt, v0);
    chk("abort_lft", lft_ld, 0);
    chk("abort_rght", rght_ld, 0);
    chk("abort_busy", busy, 0);
    sz = cmd_log.size();
    convert(12'h456);
    chk("abort_next_cmd", (cmd_log.size() > sz) ? cmd_log[sz] : 16'hFFFF, 16'h0000);
    chk("abort_next_lft", lft_ld, 12'h456);
    chk("abort_next_rght", rght_ld, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
